// File: rtl/word_select_pkg.sv
// Shared types, defaults and the saturating-increment helper for word_select_pipe.
package word_select_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 16;

    typedef logic [WIDTH_DEF-1:0] word_t;

    // Counter widths up to 32 bits are supported; the caller truncates the result.
    function automatic logic [31:0] sat_inc(input logic [31:0] count, input int unsigned cnt_w);
        logic [31:0] max_v;
        max_v = (cnt_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cnt_w) - 32'd1);
        return (count >= max_v) ? count : count + 32'd1;
    endfunction

endpackage

// File: rtl/word_select_slice.sv
// One valid/ready register slice; payload is loaded on accept and held while stalled.
module word_select_slice
    import word_select_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_up_valid,
    output logic          o_up_ready,
    input  logic [PW-1:0] i_up_data,
    output logic          o_down_valid,
    input  logic          i_down_ready,
    output logic [PW-1:0] o_down_data
);

    logic          r_valid;
    logic [PW-1:0] r_data;

    assign o_up_ready   = !r_valid || i_down_ready;
    assign o_down_valid = r_valid;
    assign o_down_data  = r_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_up_valid && o_up_ready) begin
            r_valid <= 1'b1;
            r_data  <= i_up_data;
        end else if (i_down_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/word_select_pipe.sv
// Two-stage pipelined word selector with range flag and saturating transfer counter.
// Optional parity output enabled by defining WSP_PARITY_EN.
module word_select_pipe
    import word_select_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int SEL_W = $clog2(DEPTH),
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DEPTH-1:0][WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0]            sel_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    output logic [WIDTH-1:0]            data_o,
    output logic                        sel_err_o,
    output logic                        valid_o,
    input  logic                        ready_i,
`ifdef WSP_PARITY_EN
    output logic                        parity_o,
`endif
    output logic [CNT_W-1:0]            xfer_cnt_o
);

    localparam int S1_W = DEPTH * WIDTH + SEL_W;
`ifdef WSP_PARITY_EN
    localparam int S2_W = WIDTH + 2;
`else
    localparam int S2_W = WIDTH + 1;
`endif
    localparam logic [SEL_W:0] DEPTH_V = (SEL_W + 1)'(DEPTH);

    logic [S1_W-1:0]             w_s1_in;
    logic [S1_W-1:0]             w_s1_out;
    logic                        w_s1_valid;
    logic [DEPTH-1:0][WIDTH-1:0] w_s1_data;
    logic [SEL_W-1:0]            w_s1_sel;
    logic                        w_s2_ready;
    logic [S2_W-1:0]             w_s2_in;
    logic [S2_W-1:0]             w_s2_out;
    logic [WIDTH-1:0]            w_word;
    logic                        w_err;
    logic [CNT_W-1:0]            r_cnt;
    logic [CNT_W-1:0]            w_cnt_inc;

    assign w_s1_in = {data_i, sel_i};

    word_select_slice #(.PW(S1_W)) u_stage1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_up_valid   (valid_i),
        .o_up_ready   (ready_o),
        .i_up_data    (w_s1_in),
        .o_down_valid (w_s1_valid),
        .i_down_ready (w_s2_ready),
        .o_down_data  (w_s1_out)
    );

    assign w_s1_data = w_s1_out[S1_W-1:SEL_W];
    assign w_s1_sel  = w_s1_out[SEL_W-1:0];

    // With DEPTH a power of two the compare is constant true and w_err folds to 0.
    always_comb begin
        w_err  = !({1'b0, w_s1_sel} < DEPTH_V);
        w_word = '0;
        if (!w_err) begin
            w_word = w_s1_data[w_s1_sel];
        end
    end

`ifdef WSP_PARITY_EN
    assign w_s2_in = {w_word, w_err, ^w_word};
`else
    assign w_s2_in = {w_word, w_err};
`endif

    word_select_slice #(.PW(S2_W)) u_stage2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_up_valid   (w_s1_valid),
        .o_up_ready   (w_s2_ready),
        .i_up_data    (w_s2_in),
        .o_down_valid (valid_o),
        .i_down_ready (ready_i),
        .o_down_data  (w_s2_out)
    );

`ifdef WSP_PARITY_EN
    assign data_o    = w_s2_out[S2_W-1:2];
    assign sel_err_o = w_s2_out[1];
    assign parity_o  = w_s2_out[0];
`else
    assign data_o    = w_s2_out[S2_W-1:1];
    assign sel_err_o = w_s2_out[0];
`endif

    assign w_cnt_inc = CNT_W'(sat_inc(32'(r_cnt), CNT_W));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (valid_o && ready_i) begin
            r_cnt <= w_cnt_inc;
        end
    end

    assign xfer_cnt_o = r_cnt;

endmodule

// File: tb/tb_word_select_pipe.sv
// Directed bench: a DEPTH=32 instance for latency/streaming/backpressure and a
// DEPTH=20, CNT_W=4 instance for range errors, saturation and mid-flight reset.
module tb_word_select_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [31:0][31:0] a_data;
    logic [4:0]        a_sel;
    logic              a_valid, a_ready_o, a_valid_o, a_ready_i, a_err;
    logic [31:0]       a_data_o;
    logic [15:0]       a_cnt;

    logic [19:0][31:0] b_data;
    logic [4:0]        b_sel;
    logic              b_valid, b_ready_o, b_valid_o, b_ready_i, b_err;
    logic [31:0]       b_data_o;
    logic [3:0]        b_cnt;
`ifdef WSP_PARITY_EN
    logic a_par, b_par, last_par;
`endif

    int n_checks = 0;
    int n_err    = 0;

    word_select_pipe #(.WIDTH(32), .DEPTH(32), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .data_i(a_data), .sel_i(a_sel), .valid_i(a_valid),
        .ready_o(a_ready_o), .data_o(a_data_o), .sel_err_o(a_err), .valid_o(a_valid_o),
        .ready_i(a_ready_i),
`ifdef WSP_PARITY_EN
        .parity_o(a_par),
`endif
        .xfer_cnt_o(a_cnt)
    );

    word_select_pipe #(.WIDTH(32), .DEPTH(20), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .data_i(b_data), .sel_i(b_sel), .valid_i(b_valid),
        .ready_o(b_ready_o), .data_o(b_data_o), .sel_err_o(b_err), .valid_o(b_valid_o),
        .ready_i(b_ready_i),
`ifdef WSP_PARITY_EN
        .parity_o(b_par),
`endif
        .xfer_cnt_o(b_cnt)
    );

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t tbl[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic req_b(input logic [4:0] sel, input logic [31:0] exp_d, input logic exp_e);
        b_sel     = sel;
        b_valid   = 1'b1;
        b_ready_i = 1'b1;
        tick();
        b_valid = 1'b0;
        chk1("b_latency_n1", b_valid_o, 1'b0);
        tick();
        chk1("b_valid_n2", b_valid_o, 1'b1);
        chk("b_data", b_data_o, exp_d);
        chk1("b_err", b_err, exp_e);
`ifdef WSP_PARITY_EN
        last_par = b_par;
`endif
        tick();
    endtask

    initial begin
        int exp_idx;
        int low_cnt;

        tbl[0] = '{5'd0,  32'hB000_0000, 1'b0};
        tbl[1] = '{5'd7,  32'hB000_0007, 1'b0};
        tbl[2] = '{5'd25, 32'h0000_0000, 1'b1};
        tbl[3] = '{5'd19, 32'hB000_0013, 1'b0};
        tbl[4] = '{5'd20, 32'h0000_0000, 1'b1};
        tbl[5] = '{5'd31, 32'h0000_0000, 1'b1};

        for (int k = 0; k < 32; k++) a_data[k] = 32'hA000_0000 + 32'(k);
        for (int k = 0; k < 20; k++) b_data[k] = 32'hB000_0000 + 32'(k);
        a_sel = '0; a_valid = 1'b0; a_ready_i = 1'b0;
        b_sel = '0; b_valid = 1'b0; b_ready_i = 1'b0;

        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        chk1("rst_valid_o", a_valid_o, 1'b0);
        chk("rst_data_o", a_data_o, 32'h0);
        chk1("rst_sel_err", a_err, 1'b0);
        chk("rst_cnt", 32'(a_cnt), 32'd0);
        chk1("rst_ready_o", a_ready_o, 1'b1);
        chk1("rst_b_ready_o", b_ready_o, 1'b1);

        // single request, sel 5
        a_ready_i = 1'b1;
        a_sel = 5'd5; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        chk1("a_latency_n1", a_valid_o, 1'b0);
        tick();
        chk1("a_valid_n2", a_valid_o, 1'b1);
        chk("a_data_sel5", a_data_o, 32'hA000_0005);
        chk1("a_err_sel5", a_err, 1'b0);
`ifdef WSP_PARITY_EN
        chk1("a_parity_sel5", a_par, 1'b0);
`endif
        tick();
        chk("a_cnt_single", 32'(a_cnt), 32'd1);
        chk1("a_valid_after", a_valid_o, 1'b0);

        // streaming 0..31
        exp_idx = 0;
        low_cnt = 0;
        for (int c = 0; c < 34; c++) begin
            if (c < 32) begin
                a_sel = 5'(c);
                a_valid = 1'b1;
                if (!a_ready_o) low_cnt++;
            end else begin
                a_valid = 1'b0;
            end
            tick();
            if (a_valid_o) begin
                chk("stream_data", a_data_o, 32'hA000_0000 + 32'(exp_idx));
                exp_idx++;
            end
        end
        chk("stream_words", 32'(exp_idx), 32'd32);
        chk("stream_ready_low", 32'(low_cnt), 32'd0);
        chk("stream_cnt", 32'(a_cnt), 32'd33);

        // backpressure
        a_ready_i = 1'b0;
        a_sel = 5'd3; a_valid = 1'b1;
        tick();
        chk1("bp_ready_after1", a_ready_o, 1'b1);
        a_sel = 5'd4;
        tick();
        chk1("bp_valid_o", a_valid_o, 1'b1);
        chk1("bp_ready_after2", a_ready_o, 1'b0);
        chk("bp_data_first", a_data_o, 32'hA000_0003);
        a_sel = 5'd9;
        tick();
        tick();
        chk1("bp_ready_held", a_ready_o, 1'b0);
        chk("bp_data_held", a_data_o, 32'hA000_0003);
        chk("bp_cnt_held", 32'(a_cnt), 32'd33);
        a_ready_i = 1'b1;
        #1;
        chk1("bp_ready_comb", a_ready_o, 1'b1);
        tick();
        a_valid = 1'b0;
        chk1("bp_valid_2", a_valid_o, 1'b1);
        chk("bp_data_2", a_data_o, 32'hA000_0004);
        tick();
        chk("bp_data_3", a_data_o, 32'hA000_0009);
        tick();
        chk1("bp_drained", a_valid_o, 1'b0);
        chk("bp_cnt", 32'(a_cnt), 32'd36);

        // range table on DEPTH=20
        for (int i = 0; i < 6; i++) begin
            req_b(tbl[i].sel, tbl[i].exp_data, tbl[i].exp_err);
        end
        chk("b_cnt_table", 32'(b_cnt), 32'd6);

`ifdef WSP_PARITY_EN
        b_data[7] = 32'h0000_0007;
        req_b(5'd7, 32'h0000_0007, 1'b0);
        chk1("parity_7", last_par, 1'b1);
        b_data[3] = 32'h0000_0003;
        req_b(5'd3, 32'h0000_0003, 1'b0);
        chk1("parity_3", last_par, 1'b0);
        req_b(5'd25, 32'h0, 1'b1);
        chk1("parity_err", last_par, 1'b0);
`endif

        // saturation at 15
        b_ready_i = 1'b1;
        b_sel = 5'd1; b_valid = 1'b1;
        repeat (20) tick();
        b_valid = 1'b0;
        repeat (3) tick();
        chk("b_cnt_sat", 32'(b_cnt), 32'd15);

        // reset with two in flight
        b_ready_i = 1'b0;
        b_sel = 5'd2; b_valid = 1'b1;
        tick();
        tick();
        b_valid = 1'b0;
        chk1("b_inflight_valid", b_valid_o, 1'b1);
        chk1("b_inflight_full", b_ready_o, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk1("midrst_valid_o", b_valid_o, 1'b0);
        chk("midrst_cnt", 32'(b_cnt), 32'd0);
        chk1("midrst_ready_o", b_ready_o, 1'b1);
        b_ready_i = 1'b1;
        low_cnt = 0;
        repeat (4) begin
            tick();
            if (b_valid_o) low_cnt++;
        end
        chk("midrst_stale", 32'(low_cnt), 32'd0);
        chk("midrst_cnt_after", 32'(b_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
